// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load-store unit: funct3 size codes, FSM state
// type and the request-formatting helpers used when a request is captured.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // An access is legal when its size code exists, it is naturally aligned,
    // and unsigned size codes are used only for loads.
    function automatic logic access_legal(input logic       we,
                                          input logic [2:0] size,
                                          input logic [1:0] off);
        logic legal;
        legal = 1'b0;
        case (size)
            LDST_B:  legal = 1'b1;
            LDST_H:  legal = ~off[0];
            LDST_W:  legal = (off == 2'b00);
            LDST_BU: legal = ~we;
            LDST_HU: legal = ~we & ~off[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Byte lanes touched inside the addressed word; loads use the same mask.
    function automatic logic [3:0] byte_enable(input logic [2:0] size,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane so the byte
    // enables alone select what the memory writes.
    function automatic logic [31:0] store_data(input logic [2:0]  size,
                                               input logic [31:0] wd);
        logic [31:0] data;
        case (size)
            LDST_B, LDST_BU: data = {4{wd[7:0]}};
            LDST_H, LDST_HU: data = {2{wd[15:0]}};
            default:         data = wd;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load-store unit. The slave
// modport is the LSU itself; the master modport is its environment (core
// pipeline plus data memory).
interface riscv_lsu_if #(
    parameter int ADDR_W = 32
);
    // core side
    logic              core_req_i;
    logic              core_we_i;
    logic [2:0]        core_size_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wd_i;
    logic [31:0]       core_rd_o;
    logic              core_stall_o;
    logic              lsu_err_o;
    // memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wd_o;
    logic [31:0]       mem_rd_i;
    logic              mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output core_rd_o, core_stall_o, lsu_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  core_rd_o, core_stall_o, lsu_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or
// zero-extends it according to the load size code.
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] rd_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; purely combinational.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rd_ext   = '0;
        byte_sel = rd_word[{off, 3'b000} +: 8];
        half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            LDST_B:  rd_ext = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd_ext = {24'd0, byte_sel};
            LDST_H:  rd_ext = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd_ext = {16'd0, half_sel};
            LDST_W:  rd_ext = rd_word;
            default: rd_ext = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one byte/half/word access at a time between the core's
// data port and a variable-latency word memory. The core is stalled until
// the DONE cycle; misaligned or invalid accesses skip memory and flag an
// error instead.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    riscv_lsu_if.slave  bus
);

    lsu_state_t        state_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wd_q;
    logic [31:0]       load_ext;

    lsu_load_align u_load_align (
        .rd_word (bus.mem_rd_i),
        .size    (size_q),
        .off     (off_q),
        .rd_ext  (load_ext)
    );

    // Request FSM: capture in IDLE, wait for the memory in REQ, release the
    // core for exactly one cycle in DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: reset is asynchronous so mem_req_o drops the moment rst_i rises, not at the next edge.
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= LDST_B;
            off_q      <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (bus.core_req_i) begin
                        we_q       <= bus.core_we_i;
                        size_q     <= bus.core_size_i;
                        off_q      <= bus.core_addr_i[1:0];
                        mem_we_q   <= bus.core_we_i;
                        mem_be_q   <= byte_enable(bus.core_size_i, bus.core_addr_i[1:0]);
                        mem_addr_q <= {bus.core_addr_i[ADDR_W-1:2], 2'b00};
                        mem_wd_q   <= store_data(bus.core_size_i, bus.core_wd_i);
                        if (access_legal(bus.core_we_i, bus.core_size_i, bus.core_addr_i[1:0])) begin
                            mem_req_q <= 1'b1;
                            state_q   <= REQ;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= DONE;
                        end
                    end
                end
                REQ: begin
                    // mem_* stay frozen until the memory accepts the request
                    if (bus.mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= load_ext;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The stall must follow core_req_i within the same cycle, so it is
    // combinational; DONE is the only cycle the core may commit.
    assign bus.core_stall_o = bus.core_req_i & (state_q != DONE);
    assign bus.lsu_err_o    = err_q;
    assign bus.core_rd_o    = rdata_q;
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_be_o     = mem_be_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: each access pushes its expected core
// response and memory transaction; two monitors pop and compare whenever
// the DUT completes to the core or the memory handshakes.
module tb_riscv_lsu;

    logic clk;
    logic rst;

    riscv_lsu_if #(.ADDR_W(32)) bus ();

    riscv_lsu #(.ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } core_exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd_word;
        int          waits;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_stall;
    } vec_t;

    core_exp_t core_q[$];
    mem_exp_t  mem_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Core-side monitor: a DONE cycle is a request with stall released.
    always @(negedge clk) begin
        if (!rst && bus.core_req_i && !bus.core_stall_o) begin
            if (core_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL core_unexpected_done at %0t", $time);
            end else begin
                core_exp_t e;
                e = core_q.pop_front();
                check("core_rd", bus.core_rd_o, e.rd);
                check("lsu_err", {31'd0, bus.lsu_err_o}, {31'd0, e.err});
                check("mem_req_in_done", {31'd0, bus.mem_req_o}, 32'd0);
            end
        end
    end

    // Memory-side monitor: compare the request fields when memory accepts.
    always @(negedge clk) begin
        if (!rst && bus.mem_req_o && bus.mem_ready_i) begin
            if (mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected_req at %0t", $time);
            end else begin
                mem_exp_t m;
                m = mem_q.pop_front();
                check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, m.we});
                check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, m.be});
                check("mem_addr", bus.mem_addr_o, m.addr);
                check("mem_wd", bus.mem_wd_o, m.wd);
            end
        end
    end

    // Runs one access starting just after a rising edge; plays the memory,
    // counts stall and request cycles, and returns the cycles taken.
    task automatic run_access(input vec_t v, output int cycles);
        int  stall_cnt;
        int  req_cnt;
        int  w;
        bit  done;
        core_q.push_back('{rd: v.exp_rd, err: v.exp_err});
        if (!v.exp_err) begin
            mem_q.push_back('{we: v.we, be: v.exp_be, addr: v.exp_addr, wd: v.exp_wd});
        end
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = v.we;
        bus.core_size_i = v.size;
        bus.core_addr_i = v.addr;
        bus.core_wd_i   = v.wd;
        stall_cnt = 0;
        req_cnt   = 0;
        w         = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus.mem_ready_i = 1'b0;
            bus.mem_rd_i    = 32'h0;
            if (bus.mem_req_o) begin
                if (w == v.waits) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rd_i    = v.rd_word;
                end else begin
                    w++;
                end
            end
            @(negedge clk);
            if (bus.mem_req_o) req_cnt++;
            if (bus.core_stall_o) stall_cnt++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout addr %08h at %0t", v.addr, $time);
        end
        check("stall_cycles", stall_cnt, v.exp_stall);
        check("mem_req_cycles", req_cnt, v.exp_err ? 0 : v.waits + 1);
        check("err_one_pulse", {31'd0, bus.lsu_err_o}, 32'd0);
        check("rd_held", bus.core_rd_o, v.exp_rd);
        cycles = stall_cnt + 1;
    endtask

    vec_t vecs[12];
    vec_t v;
    int   cyc_a;
    int   cyc_b;

    initial begin
        //            we  size addr          wd            rd_word       wt  exp_rd        err   exp_addr      be       exp_wd        stall
        vecs[0]  = '{1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 32'h0,        1'b0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 2};
        vecs[1]  = '{1'b0, 3'd1, 32'h0000_2002, 32'h0,         32'h8123_4567, 3, 32'hFFFF_8123, 1'b0, 32'h0000_2000, 4'b1100, 32'h0,        5};
        vecs[2]  = '{1'b0, 3'd5, 32'h0000_2002, 32'h0,         32'h8123_4567, 3, 32'h0000_8123, 1'b0, 32'h0000_2000, 4'b1100, 32'h0,        5};
        vecs[3]  = '{1'b0, 3'd0, 32'h0000_0011, 32'h0,         32'h0000_7F00, 0, 32'h0000_007F, 1'b0, 32'h0000_0010, 4'b0010, 32'h0,        2};
        vecs[4]  = '{1'b0, 3'd4, 32'h0000_0011, 32'h0,         32'h0000_8000, 0, 32'h0000_0080, 1'b0, 32'h0000_0010, 4'b0010, 32'h0,        2};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0006, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1};
        vecs[6]  = '{1'b1, 3'd1, 32'h0000_0022, 32'h0000_BEEF, 32'h0,        1, 32'h0,        1'b0, 32'h0000_0020, 4'b1100, 32'hBEEF_BEEF, 3};
        vecs[7]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0,         32'h8000_0000, 0, 32'hFFFF_FF80, 1'b0, 32'h0000_0010, 4'b1000, 32'h0,        2};
        vecs[8]  = '{1'b1, 3'd4, 32'h0000_0000, 32'h0000_0011, 32'h0,        0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1};
        vecs[9]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h1234_F00F, 2, 32'hFFFF_F00F, 1'b0, 32'h0000_0000, 4'b0011, 32'h0,        4};
        vecs[10] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,        0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1};
        vecs[11] = '{1'b0, 3'd5, 32'h0000_2001, 32'h0,         32'h0,        0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1};

        rst             = 1'b1;
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'h0;
        bus.core_wd_i   = 32'h0;
        bus.mem_rd_i    = 32'h0;
        bus.mem_ready_i = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_mem_wd", bus.mem_wd_o, 32'd0);
        check("rst_core_rd", bus.core_rd_o, 32'd0);
        check("rst_lsu_err", {31'd0, bus.lsu_err_o}, 32'd0);
        bus.core_req_i = 1'b1;
        #1;
        check("rst_stall_follows_req", {31'd0, bus.core_stall_o}, 32'd1);
        bus.core_req_i = 1'b0;
        #1;
        check("rst_stall_drops", {31'd0, bus.core_stall_o}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // directed vectors
        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i], cyc_a);
        end

        // SW at 0x40 aborted by reset while in REQ
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b1;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h0000_0040;
        bus.core_wd_i   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("abort_mem_req_up", {31'd0, bus.mem_req_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_req_async", {31'd0, bus.mem_req_o}, 32'd0);
        check("abort_state_idle", {31'd0, bus.core_stall_o}, 32'd1);
        check("abort_core_rd", bus.core_rd_o, 32'd0);
        bus.core_req_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        v = '{1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0,
              32'h0000_0040, 4'b1111, 32'h0, 2};
        run_access(v, cyc_a);

        // back-to-back SW then LW, ready on the first REQ cycle of each
        v = '{1'b1, 3'd2, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0, 0, 32'h1234_5678, 1'b0,
              32'h0000_0044, 4'b1111, 32'hDEAD_BEEF, 2};
        run_access(v, cyc_a);
        v = '{1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0,
              32'h0000_0044, 4'b1111, 32'h0, 2};
        run_access(v, cyc_b);
        check("b2b_total_cycles", cyc_a + cyc_b, 6);

        repeat (2) @(posedge clk);
        check("core_q_drained", core_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
